ipif_param_bank: RTL and testbench
==================================

// Module: ipif_param_bank
// PURPOSE
//  Parametrised IPIF register bank: N_REG words of PARAM_T parameters to the IP, status readback from it.
//  Adds byte-enable writes, per-bit write masks, self-reset bits cleared on IP ack or watchdog timeout,
//  per-register write/read strobes, error on multi-hot CE, selectable readback latency.
//  Sits between the AXI-IPIF slave and a core's control/status struct.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH 32    bus word width; multiple of 8
//  N_REG              4     number of registers
//  PARAM_T            logic[N_REG*C_S_AXI_DATA_WIDTH-1:0]  packed parameter struct
//  DEFAULTS           '0    reset/default value of parameters_out
//  SELF_RESET         '0    1 = bit returns to DEFAULTS after IP ack or timeout
//  WRITE_MASK         '1    1 = bit writable from bus; 0 = bit holds DEFAULTS forever
//  SR_TIMEOUT         0     cycles after write before self-reset bits force default; 0 = no timeout
//  RD_LATENCY         1     1 or 2 cycles from rdce to rdack
// PORTS
//  clk                 in  1      clock
//  IPIF_bus2ip_reset   in  1      async reset, active-high
//  IPIF_bus2ip_data    in  DW     write data
//  IPIF_bus2ip_be      in  DW/8   byte enables
//  IPIF_bus2ip_wrce    in  N_REG  one-hot write chip-enable
//  IPIF_bus2ip_rdce    in  N_REG  one-hot read chip-enable
//  IPIF_ip2bus_data    out DW     read data
//  IPIF_ip2bus_wrack   out 1      write ack
//  IPIF_ip2bus_rdack   out 1      read ack
//  IPIF_ip2bus_error   out 1      error, valid with either ack
//  parameters_out      out PARAM_T  registered parameters to IP
//  parameters_in       in  PARAM_T  status/readback from IP
//  wr_strobe           out N_REG  1-cycle pulse, register i updated from bus
//  rd_strobe           out N_REG  1-cycle pulse, register i read (pop side effects)
// BEHAVIOUR
//  Reset: parameters_out=DEFAULTS, all acks/error/strobes/data=0, timeout counters=0.
//  Write: wrce one-hot bit i -> next edge reg[i][b] <= data[b] where be[b/8]&WRITE_MASK[i][b], else held;
//   wrack=1 and wr_strobe[i]=1 on that same edge (1-cycle latency), error=0.
//  wrce multi-hot: no register changes, no wr_strobe, wrack=1 with error=1. wrce=0: nothing.
//  Self-reset, bit with SELF_RESET=1 and no write this cycle: if parameters_in bit != DEFAULTS bit
//   (IP ack) -> bit <= DEFAULTS next edge.
//  Timeout (SR_TIMEOUT>0): write to reg i loads cnt[i]=SR_TIMEOUT; decrements each cycle while >0;
//   on 1->0 transition all SELF_RESET bits of reg i <= DEFAULTS. Rewrite reloads; write wins over clear.
//  Read: rdce one-hot bit i -> data=parameters_in word i, rdack=1, rd_strobe[i]=1; strobe on first
//   cycle, data/ack after RD_LATENCY cycles (2 = extra pipeline register on mux output).
//  rdce multi-hot: data=0, rdack=1, error=1, no rd_strobe.
//  rdce/wrce held >1 cycle (IPIF holds CE until ack): each still yields exactly one ack and one strobe;
//   edge-detect CE (rising) internally; a new transaction needs CE to deassert first.
//  Simultaneous rdce and wrce: both serviced independently; readback shows pre-write parameters_in.
//  Reset mid-transaction: all pending acks dropped, counters cleared, parameters_out=DEFAULTS.
// STRUCTURE
//  Package ipif_pkg: param_union_t-style word-array union helper, RD_LATENCY enum, onehot check function.
//  Sub-module ipif_sr_timer (one per register via generate): loadable down-counter, expire pulse.
//  Top: write decode/merge, self-reset logic, read mux + latency pipe, ack/error generation.
// TESTING
//  Reset with DEFAULTS=0x...A5 in reg0 -> parameters_out reg0=0xA5, all acks 0.
//  wrce=0001, data=0xDEADBEEF, be=0011 -> reg0=0x????BEEF (upper bytes unchanged), wrack+wr_strobe[0] one cycle.
//  SELF_RESET reg1 bit0, write 1, drive parameters_in bit0=1 next cycle -> parameters_out bit0=0 one edge later.
//  SR_TIMEOUT=8, write 1 to SR bit, IP never acks -> bit clears exactly 8 cycles after write edge.
//  wrce=0011 -> wrack=1,error=1, regs unchanged; rdce=0110 -> rdack=1,error=1,data=0.
//  RD_LATENCY=2, rdce=0100 held 4 cycles -> rd_strobe[2] once, rdack once 2 cycles later, data=parameters_in word2.

Source files
------------

// File: rtl/ipif_pkg.sv
// Shared types and helpers for the IPIF parameter bank: readback latency
// selector and the one-hot chip-enable check used on both bus directions.
package ipif_pkg;

   // Readback latency options: direct mux register or one extra pipeline stage.
   typedef enum logic [1:0] {
      RD_LAT_1 = 2'd1,
      RD_LAT_2 = 2'd2
   } rd_lat_e;

   // Widest chip-enable vector the one-hot helper accepts.
   localparam int unsigned CE_MAX_W = 32;

   // True when exactly one bit of the (zero-extended) chip-enable vector is set.
   function automatic logic is_onehot(input logic [CE_MAX_W-1:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/ipif_sr_timer.sv
// Loadable down-counter that flags the cycle on which it steps from 1 to 0.
// A load always wins over the expiry, so rewriting a register restarts the wait.
module ipif_sr_timer
   import ipif_pkg::*;
#(
   parameter int unsigned TIMEOUT = 0,
   parameter int unsigned CNT_W   = 1
)(
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   output logic expire_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count and expiry flag: reload on write, otherwise count down to zero.
   always_comb begin
      cnt_d    = cnt_q;
      expire_o = 1'b0;
      if (load_i) begin
         cnt_d = CNT_W'(TIMEOUT);
      end else if (cnt_q != '0) begin
         cnt_d    = cnt_q - CNT_W'(1);
         expire_o = (cnt_q == CNT_W'(1));
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register, cleared by the bus reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ipif_param_bank.sv
// IPIF register bank: bus-writable parameter words driven to the IP core and
// status words read back from it. Chip-enables are edge-detected so a CE held
// until ack produces exactly one transaction.
module ipif_param_bank
   import ipif_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int N_REG              = 4,
   parameter type PARAM_T           = logic [N_REG*C_S_AXI_DATA_WIDTH-1:0],
   parameter PARAM_T DEFAULTS       = '0,
   parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] SELF_RESET = '0,
   parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] WRITE_MASK = '1,
   parameter int SR_TIMEOUT         = 0,
   parameter int RD_LATENCY         = 1
)(
   input  logic                            clk,
   input  logic                            IPIF_bus2ip_reset,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_bus2ip_data,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] IPIF_bus2ip_be,
   input  logic [N_REG-1:0]                IPIF_bus2ip_wrce,
   input  logic [N_REG-1:0]                IPIF_bus2ip_rdce,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_ip2bus_data,
   output logic                            IPIF_ip2bus_wrack,
   output logic                            IPIF_ip2bus_rdack,
   output logic                            IPIF_ip2bus_error,
   output PARAM_T                          parameters_out,
   input  PARAM_T                          parameters_in,
   output logic [N_REG-1:0]                wr_strobe,
   output logic [N_REG-1:0]                rd_strobe
);

   localparam int DW    = C_S_AXI_DATA_WIDTH;
   localparam int PW    = N_REG * DW;
   localparam int CNT_W = (SR_TIMEOUT > 0) ? $clog2(SR_TIMEOUT + 1) : 1;
   localparam logic [PW-1:0] DFLT   = DEFAULTS;
   localparam rd_lat_e       RD_LAT = (RD_LATENCY == 2) ? RD_LAT_2 : RD_LAT_1;

   // Flat vector overlaid with a word array so the bank can be handled either way.
   typedef union packed {
      logic [PW-1:0]                flat;
      logic [N_REG-1:0][DW-1:0]     word;
   } bank_u;

   bank_u             par_q, par_d, pin_s;
   logic [DW-1:0]     be_bits_s;
   logic [N_REG-1:0]  wr_hit_s, expire_s;
   logic              wr_any_q, rd_any_q;
   logic              wr_start_s, wr_ok_s, wr_bad_s;
   logic              rd_start_s, rd_ok_s, rd_bad_s;
   logic [DW-1:0]     rd_mux_s, rd_now_s;
   logic              rsp_vld_s, rsp_err_s;
   logic [DW-1:0]     rsp_data_s;
   logic              wrack_q, rdack_q, err_q;
   logic [DW-1:0]     rdata_q;
   logic [N_REG-1:0]  wr_strobe_q, rd_strobe_q;

   assign pin_s.flat = parameters_in;

   // A transaction starts only on the cycle a CE vector leaves all-zero.
   assign wr_start_s = (|IPIF_bus2ip_wrce) & ~wr_any_q;
   assign wr_ok_s    = wr_start_s & is_onehot(CE_MAX_W'(IPIF_bus2ip_wrce));
   assign wr_bad_s   = wr_start_s & ~wr_ok_s;
   assign wr_hit_s   = wr_ok_s ? IPIF_bus2ip_wrce : '0;
   assign rd_start_s = (|IPIF_bus2ip_rdce) & ~rd_any_q;
   assign rd_ok_s    = rd_start_s & is_onehot(CE_MAX_W'(IPIF_bus2ip_rdce));
   assign rd_bad_s   = rd_start_s & ~rd_ok_s;

   // One timeout counter per register; only its self-reset bits react to expiry.
   for (genvar gi = 0; gi < N_REG; gi++) begin : g_tmr
      ipif_sr_timer #(
         .TIMEOUT (SR_TIMEOUT),
         .CNT_W   (CNT_W)
      ) u_tmr (
         .clk      (clk),
         .rst      (IPIF_bus2ip_reset),
         .load_i   (wr_hit_s[gi]),
         .expire_o (expire_s[gi])
      );
   end

   // Expand byte enables to a per-bit enable.
   always_comb begin
      be_bits_s = '0;
      for (int b = 0; b < DW; b++) begin
         be_bits_s[b] = IPIF_bus2ip_be[b/8];
      end
   end

   // Next parameter bank: bus write merge has priority over IP-ack/timeout self-reset.
   always_comb begin
      par_d = par_q;
      for (int i = 0; i < N_REG; i++) begin
         for (int b = 0; b < DW; b++) begin
            if (wr_hit_s[i]) begin
               if (be_bits_s[b] && WRITE_MASK[i*DW+b]) begin
                  par_d.flat[i*DW+b] = IPIF_bus2ip_data[b];
               end else begin
                  par_d.flat[i*DW+b] = par_q.flat[i*DW+b];
               end
            end else if (SELF_RESET[i*DW+b] &&
                         (expire_s[i] || (pin_s.flat[i*DW+b] != DFLT[i*DW+b]))) begin
               par_d.flat[i*DW+b] = DFLT[i*DW+b];
            end else begin
               par_d.flat[i*DW+b] = par_q.flat[i*DW+b];
            end
         end
      end
   end

   // Readback mux; a multi-hot read returns zero.
   always_comb begin
      rd_mux_s = '0;
      for (int i = 0; i < N_REG; i++) begin
         if (IPIF_bus2ip_rdce[i]) begin
            rd_mux_s = pin_s.word[i];
         end else begin
            rd_mux_s = rd_mux_s;
         end
      end
      if (rd_ok_s) begin
         rd_now_s = rd_mux_s;
      end else begin
         rd_now_s = '0;
      end
   end

   if (RD_LAT == RD_LAT_2) begin : g_pipe
      logic          s1_vld_q, s1_err_q;
      logic [DW-1:0] s1_data_q;

      // Extra stage between the mux and the bus-side read registers.
      always_ff @(posedge clk or posedge IPIF_bus2ip_reset) begin
         if (IPIF_bus2ip_reset) begin
            s1_vld_q  <= 1'b0;
            s1_err_q  <= 1'b0;
            s1_data_q <= '0;
         end else begin
            s1_vld_q  <= rd_start_s;
            s1_err_q  <= rd_bad_s;
            s1_data_q <= rd_now_s;
         end
      end

      assign rsp_vld_s  = s1_vld_q;
      assign rsp_err_s  = s1_err_q;
      assign rsp_data_s = s1_data_q;
   end else begin : g_direct
      assign rsp_vld_s  = rd_start_s;
      assign rsp_err_s  = rd_bad_s;
      assign rsp_data_s = rd_now_s;
   end

   // Bank, CE history, acks, error, strobes and read data registers.
   always_ff @(posedge clk or posedge IPIF_bus2ip_reset) begin
      if (IPIF_bus2ip_reset) begin
         par_q.flat  <= DFLT;
         wr_any_q    <= 1'b0;
         rd_any_q    <= 1'b0;
         wrack_q     <= 1'b0;
         rdack_q     <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         wr_strobe_q <= '0;
         rd_strobe_q <= '0;
      end else begin
         par_q       <= par_d;
         wr_any_q    <= |IPIF_bus2ip_wrce;
         rd_any_q    <= |IPIF_bus2ip_rdce;
         wrack_q     <= wr_start_s;
         rdack_q     <= rsp_vld_s;
         err_q       <= wr_bad_s | (rsp_vld_s & rsp_err_s);
         rdata_q     <= rsp_vld_s ? rsp_data_s : '0;
         wr_strobe_q <= wr_hit_s;
         rd_strobe_q <= rd_ok_s ? IPIF_bus2ip_rdce : '0;
      end
   end

   assign parameters_out    = par_q.flat;
   assign IPIF_ip2bus_data  = rdata_q;
   assign IPIF_ip2bus_wrack = wrack_q;
   assign IPIF_ip2bus_rdack = rdack_q;
   assign IPIF_ip2bus_error = err_q;
   assign wr_strobe         = wr_strobe_q;
   assign rd_strobe         = rd_strobe_q;

endmodule

// File: tb/tb_ipif_param_bank.sv
// Directed bench for ipif_param_bank with a word-level reference model that is
// compared against every DUT output on each falling clock edge.
module tb_ipif_param_bank;

   localparam int RDL = 2;
   localparam int TO  = 8;
   localparam logic [127:0] DFLT = {32'h5A000000, 32'h00000000, 32'h00000000, 32'h000000A5};
   localparam logic [127:0] SRM  = {32'h00000000, 32'h00000000, 32'h00000011, 32'h00000000};
   localparam logic [127:0] WM   = {32'h00FFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

   logic         clk, rst;
   logic [31:0]  data;
   logic [3:0]   be, wrce, rdce;
   logic [31:0]  rdata;
   logic         wrack, rdack, err;
   logic [127:0] pout, pin;
   logic [3:0]   wrs, rds;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   ipif_param_bank #(
      .C_S_AXI_DATA_WIDTH (32),
      .N_REG              (4),
      .DEFAULTS           (DFLT),
      .SELF_RESET         (SRM),
      .WRITE_MASK         (WM),
      .SR_TIMEOUT         (TO),
      .RD_LATENCY         (RDL)
   ) dut (
      .clk               (clk),
      .IPIF_bus2ip_reset (rst),
      .IPIF_bus2ip_data  (data),
      .IPIF_bus2ip_be    (be),
      .IPIF_bus2ip_wrce  (wrce),
      .IPIF_bus2ip_rdce  (rdce),
      .IPIF_ip2bus_data  (rdata),
      .IPIF_ip2bus_wrack (wrack),
      .IPIF_ip2bus_rdack (rdack),
      .IPIF_ip2bus_error (err),
      .parameters_out    (pout),
      .parameters_in     (pin),
      .wr_strobe         (wrs),
      .rd_strobe         (rds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      int          left;
      logic [31:0] data;
      bit          err;
   } rsp_t;

   logic [31:0] m_par [4];
   int          m_cnt [4];
   bit          m_wprev, m_rprev;
   rsp_t        m_q [$];
   rsp_t        m_new;
   logic        e_wrack, e_rdack, e_err;
   logic [31:0] e_data;
   logic [3:0]  e_wrs, e_rds;
   bit          m_wstart, m_wok, m_rstart, m_rok, m_rerr, m_expd;
   logic [31:0] m_bm, m_clr;

   function automatic logic [31:0] wd(input logic [127:0] v, input int i);
      return v[i*32 +: 32];
   endfunction

   function automatic int sel(input logic [3:0] ce);
      for (int i = 0; i < 4; i++) if (ce[i]) return i;
      return 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_par[i] = wd(DFLT, i);
            m_cnt[i] = 0;
         end
         m_wprev = 1'b0; m_rprev = 1'b0;
         m_q.delete();
         e_wrack = 1'b0; e_rdack = 1'b0; e_err = 1'b0;
         e_data = 32'h0; e_wrs = 4'h0; e_rds = 4'h0;
      end else begin
         m_wstart = (wrce != 4'h0) && !m_wprev;
         m_wok    = m_wstart && ($countones(wrce) == 1);
         m_rstart = (rdce != 4'h0) && !m_rprev;
         m_rok    = m_rstart && ($countones(rdce) == 1);
         for (int i = 0; i < 4; i++) begin
            if (m_wok && wrce[i]) begin
               m_bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}} & wd(WM, i);
               m_par[i] = (m_par[i] & ~m_bm) | (data & m_bm);
               m_cnt[i] = TO;
            end else begin
               m_expd = 1'b0;
               if (m_cnt[i] > 0) begin
                  m_cnt[i] = m_cnt[i] - 1;
                  m_expd   = (m_cnt[i] == 0);
               end
               m_clr = wd(SRM, i) & (m_expd ? 32'hFFFFFFFF : (wd(pin, i) ^ wd(DFLT, i)));
               m_par[i] = (m_par[i] & ~m_clr) | (wd(DFLT, i) & m_clr);
            end
         end
         if (m_rstart) begin
            m_new.left = RDL;
            m_new.data = m_rok ? wd(pin, sel(rdce)) : 32'h0;
            m_new.err  = !m_rok;
            m_q.push_back(m_new);
         end
         foreach (m_q[k]) m_q[k].left = m_q[k].left - 1;
         e_rdack = 1'b0; e_data = 32'h0; m_rerr = 1'b0;
         if (m_q.size() > 0 && m_q[0].left == 0) begin
            e_rdack = 1'b1;
            e_data  = m_q[0].data;
            m_rerr  = m_q[0].err;
            void'(m_q.pop_front());
         end
         e_wrack = m_wstart;
         e_wrs   = m_wok ? wrce : 4'h0;
         e_rds   = m_rok ? rdce : 4'h0;
         e_err   = (m_wstart && !m_wok) || m_rerr;
         m_wprev = (wrce != 4'h0);
         m_rprev = (rdce != 4'h0);
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("parameters_out", pout, {m_par[3], m_par[2], m_par[1], m_par[0]});
         chk("wrack", 128'(wrack), 128'(e_wrack));
         chk("rdack", 128'(rdack), 128'(e_rdack));
         chk("error", 128'(err), 128'(e_err));
         chk("rdata", 128'(rdata), 128'(e_data));
         chk("wr_strobe", 128'(wrs), 128'(e_wrs));
         chk("rd_strobe", 128'(rds), 128'(e_rds));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; data = 32'h0; be = 4'h0; wrce = 4'h0; rdce = 4'h0; pin = 128'h0;
      ticks(2);
      chk_en = 1'b1;
      @(negedge clk);
      chk("lit_reset_word0", pout[31:0], 32'h000000A5);
      chk("lit_reset_acks", {wrack, rdack, err}, 3'b000);
      rst = 1'b0;
      tick();

      // Byte-enabled write to reg0, CE held three cycles.
      data = 32'hDEADBEEF; be = 4'b0011; wrce = 4'b0001;
      tick();
      @(negedge clk);
      chk("lit_wr_word0", pout[31:0], 32'h0000BEEF);
      chk("lit_wr_ack", {wrack, wrs}, 5'b1_0001);
      ticks(2);
      @(negedge clk);
      chk("lit_wr_held_noack", 128'(wrack), 128'(0));
      wrce = 4'h0;
      tick();

      // Self-reset via IP ack on bit0, timeout on bit4 of reg1.
      data = 32'h00000011; be = 4'b1111; wrce = 4'b0010;
      tick();
      wrce = 4'h0; pin[32] = 1'b1;
      tick();
      @(negedge clk);
      chk("lit_sr_ack", pout[63:32], 32'h00000010);
      ticks(6);
      @(negedge clk);
      chk("lit_sr_before_to", pout[63:32], 32'h00000010);
      tick();
      @(negedge clk);
      chk("lit_sr_timeout", pout[63:32], 32'h00000000);
      pin[32] = 1'b0;
      tick();

      // Multi-hot write.
      data = 32'hFFFFFFFF; be = 4'b1111; wrce = 4'b0011;
      tick();
      @(negedge clk);
      chk("lit_mh_wr", {wrack, err, wrs}, 6'b11_0000);
      chk("lit_mh_word0", pout[31:0], 32'h0000BEEF);
      wrce = 4'h0;
      tick();

      // Multi-hot read.
      pin[95:64] = 32'h12345678;
      rdce = 4'b0110;
      tick();
      @(negedge clk);
      chk("lit_mh_rd_early", 128'(rdack), 128'(0));
      tick();
      @(negedge clk);
      chk("lit_mh_rd", {rdack, err, rds, rdata}, {1'b1, 1'b1, 4'b0000, 32'h0});
      rdce = 4'h0;
      tick();

      // Single read of reg2 held four cycles, latency 2.
      rdce = 4'b0100;
      tick();
      @(negedge clk);
      chk("lit_rd_strobe", {rdack, rds}, 5'b0_0100);
      tick();
      @(negedge clk);
      chk("lit_rd_data", {rdack, err, rds, rdata}, {1'b1, 1'b0, 4'b0000, 32'h12345678});
      ticks(2);
      @(negedge clk);
      chk("lit_rd_held_noack", 128'(rdack), 128'(0));
      rdce = 4'h0;
      tick();

      // Simultaneous read and write of reg3 (upper byte not writable).
      pin[127:96] = 32'hCAFEF00D;
      data = 32'hFFFFFFFF; be = 4'b1111; wrce = 4'b1000; rdce = 4'b1000;
      tick();
      @(negedge clk);
      chk("lit_rw_word3", pout[127:96], 32'h5AFFFFFF);
      tick();
      @(negedge clk);
      chk("lit_rw_rdata", rdata, 32'hCAFEF00D);
      wrce = 4'h0; rdce = 4'h0;
      tick();

      // Byte-enable patterns on reg2.
      data = 32'hA1B2C3D4; be = 4'b1000; wrce = 4'b0100; tick(); wrce = 4'h0; tick();
      data = 32'h11223344; be = 4'b0101; wrce = 4'b0100; tick(); wrce = 4'h0; tick();
      data = 32'h99999999; be = 4'b0000; wrce = 4'b0100; tick(); wrce = 4'h0; tick();
      @(negedge clk);
      chk("lit_be_word2", pout[95:64], 32'hA1220044);

      // Reads of reg0 and reg1 with fresh status patterns.
      pin[31:0] = 32'h0F0F0F0F; rdce = 4'b0001; ticks(2); rdce = 4'h0; ticks(2);
      pin[63:32] = 32'h00000020; rdce = 4'b0010; ticks(3); rdce = 4'h0; ticks(2);

      // Reset in the middle of a pending read and a running timeout.
      data = 32'h00000010; be = 4'b1111; wrce = 4'b0010; tick(); wrce = 4'h0;
      rdce = 4'b0001; tick();
      rst = 1'b1; rdce = 4'h0;
      tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      chk("lit_rst_mid", {rdack, pout[63:32], pout[31:0]}, {1'b0, 32'h0, 32'h000000A5});
      ticks(12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
